// File: rtl/csa_pkg.sv
// Shared width/block constants and word type for the carry-select adder family.
package csa_pkg;

  localparam int unsigned CSA_WIDTH = 32;
  localparam int unsigned CSA_BLK   = 4;

  typedef logic [CSA_WIDTH-1:0] csa_word_t;

endpackage : csa_pkg

// File: rtl/rca_block.sv
// BLK-bit ripple-carry adder: {co, s} = a + b + ci.
module rca_block #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  // Ripple the carry bit by bit; a block-local variable avoids a self-referencing vector.
  always_comb begin
    logic w_carry;
    w_carry = ci;
    s       = '0;
    for (int i = 0; i < int'(BLK); i++) begin
      s[i]    = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    co = w_carry;
  end

endmodule : rca_block

// File: rtl/carry_select_adder_32.sv
// 32-bit unsigned carry-select adder: {cout, S} = A + B + cin.
// Block 0 ripples from cin; each upper block precomputes both carry-in cases and the real
// block carry selects the sum slice and outgoing carry.
// Optional build macro: CSA_OUTPUT_REG_EN registers S/cout (1-cycle latency, async clear).
// WIDTH must be a multiple of BLK.
module carry_select_adder_32
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned BLK   = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout
);

  localparam int unsigned NumBlk = WIDTH / BLK;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  for (genvar k = 0; k < int'(NumBlk); k++) begin : g_blk
    // Per-block carry nets keep the select chain free of a circular vector.
    logic w_ci;
    logic w_co;

    if (k == 0) begin : g_lo
      assign w_ci = cin;

      rca_block #(
        .BLK (BLK)
      ) u_rca (
        .a  (A[BLK-1:0]),
        .b  (B[BLK-1:0]),
        .ci (w_ci),
        .s  (w_sum[BLK-1:0]),
        .co (w_co)
      );
    end else begin : g_hi
      logic [BLK-1:0] w_s0;
      logic [BLK-1:0] w_s1;
      logic           w_co0;
      logic           w_co1;

      assign w_ci = g_blk[k-1].w_co;

      rca_block #(
        .BLK (BLK)
      ) u_rca0 (
        .a  (A[k*BLK +: BLK]),
        .b  (B[k*BLK +: BLK]),
        .ci (1'b0),
        .s  (w_s0),
        .co (w_co0)
      );

      rca_block #(
        .BLK (BLK)
      ) u_rca1 (
        .a  (A[k*BLK +: BLK]),
        .b  (B[k*BLK +: BLK]),
        .ci (1'b1),
        .s  (w_s1),
        .co (w_co1)
      );

      // Real block carry picks the precomputed result.
      assign w_sum[k*BLK +: BLK] = w_ci ? w_s1  : w_s0;
      assign w_co                = w_ci ? w_co1 : w_co0;
    end
  end

  assign w_cout = g_blk[NumBlk-1].w_co;

`ifdef CSA_OUTPUT_REG_EN
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Output register; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign S    = r_sum;
  assign cout = r_cout;
`else
  // Combinational build: clock and reset are intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign S    = w_sum;
  assign cout = w_cout;
`endif

endmodule : carry_select_adder_32

// File: tb/tb_carry_select_adder_32.sv
// Directed + random checks for carry_select_adder_32 (combinational or registered build).
module tb_carry_select_adder_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] s;
  logic        cout;

  int n_pass  = 0;
  int n_total = 0;

  carry_select_adder_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b),
    .cin   (cin),
    .S     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand triple and wait until the result is observable.
  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
`ifdef CSA_OUTPUT_REG_EN
    @(negedge clk);
    a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
`else
    a = ta; b = tb; cin = tc;
    #10;
`endif
  endtask

  task automatic test_reset();
`ifdef CSA_OUTPUT_REG_EN
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({cout, s} !== 33'h0)
      $display("FAIL reset_clear got %h_%h want 0_00000000", cout, s);
    else n_pass++;
    @(negedge clk);
    a = 32'd5; b = 32'd6; cin = 1'b0;
    #1;
    n_total++;
    if ({cout, s} !== 33'h0)
      $display("FAIL reset_hold got %h_%h want 0_00000000", cout, s);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({cout, s} !== 33'h0)
      $display("FAIL reset_release_early got %h_%h want 0_00000000", cout, s);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({cout, s} !== 33'd11)
      $display("FAIL reset_first_edge got %h_%h want 0_0000000b", cout, s);
    else n_pass++;
`else
    // Reset must not affect the combinational build.
    rst_n = 1'b0;
    drive(32'd5, 32'd6, 1'b0);
    n_total++;
    if ({cout, s} !== 33'd11)
      $display("FAIL reset_ignored got %h_%h want 0_0000000b", cout, s);
    else n_pass++;
    rst_n = 1'b1;
    #3;
    n_total++;
    if ({cout, s} !== 33'd11)
      $display("FAIL reset_release got %h_%h want 0_0000000b", cout, s);
    else n_pass++;
`endif
  endtask

  task automatic test_sweep(input logic tc);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(32'(i), 32'(j), tc);
        n_total++;
        if ({cout, s} !== 33'(i + j + int'(tc)))
          $display("FAIL sweep cin=%b A=%0d B=%0d got %0d want %0d",
                   tc, i, j, {cout, s}, i + j + int'(tc));
        else n_pass++;
      end
    end
  endtask

  task automatic test_boundary();
    drive(32'h0000_000F, 32'h0000_0001, 1'b0);
    n_total++;
    if ({cout, s} !== {1'b0, 32'h0000_0010})
      $display("FAIL block_boundary got %h_%h want 0_00000010", cout, s);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    n_total++;
    if ({cout, s} !== {1'b1, 32'h0000_0000})
      $display("FAIL wrap_plus1 got %h_%h want 1_00000000", cout, s);
    else n_pass++;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    n_total++;
    if ({cout, s} !== {1'b1, 32'hFFFF_FFFF})
      $display("FAIL wrap_max got %h_%h want 1_ffffffff", cout, s);
    else n_pass++;
  endtask

  task automatic test_chain();
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    n_total++;
    if ({cout, s} !== {1'b0, 32'h8000_0000})
      $display("FAIL long_chain got %h_%h want 0_80000000", cout, s);
    else n_pass++;
    drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    n_total++;
    if ({cout, s} !== {1'b0, 32'h2222_2222})
      $display("FAIL mixed_digits got %h_%h want 0_22222222", cout, s);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] exp_v;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      exp_v = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      drive(ra, rb, rc);
      n_total++;
      if ({cout, s} !== exp_v)
        $display("FAIL random A=%h B=%h cin=%b got %h want %h", ra, rb, rc, {cout, s}, exp_v);
      else n_pass++;
    end
  endtask

`ifdef CSA_OUTPUT_REG_EN
  task automatic test_reg_midstream();
    drive(32'd7, 32'd8, 1'b0);
    n_total++;
    if ({cout, s} !== 33'd15)
      $display("FAIL mid_before got %0d want 15", {cout, s});
    else n_pass++;
    @(negedge clk);
    a = 32'd1; b = 32'd2; cin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({cout, s} !== 33'h0)
      $display("FAIL mid_async_clear got %h_%h want 0_00000000", cout, s);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({cout, s} !== 33'h0)
      $display("FAIL mid_discard got %h_%h want 0_00000000", cout, s);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if ({cout, s} !== 33'd3)
      $display("FAIL mid_resume got %0d want 3", {cout, s});
    else n_pass++;
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    test_reset();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_boundary();
    test_wrap();
    test_chain();
    test_random();
`ifdef CSA_OUTPUT_REG_EN
    test_reg_midstream();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_carry_select_adder_32
